// File: rtl/mpx_nto1_stream.sv
// mpx_nto1_stream: N-to-1 stream multiplexer with fixed-select or round-robin arbitration and a registered output stage
module mpx_nto1_stream #(
    parameter int NB_DATA  = 32,
    parameter int N_INPUTS = 4,
    parameter int NB_SEL   = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_INPUTS*NB_DATA-1:0]  i_data,
    input  logic [N_INPUTS-1:0]          i_valid,
    output logic [N_INPUTS-1:0]          o_ready,
    input  logic                         i_mode,
    input  logic [NB_SEL-1:0]            i_sel,
    output logic [NB_DATA-1:0]           o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [NB_SEL-1:0]            o_grant
);
    logic [NB_DATA-1:0] r_data;
    logic               r_valid;
    logic [NB_SEL-1:0]  r_grant;
    logic [NB_SEL-1:0]  r_rr_ptr;
    logic               w_load_en;
    logic               w_gnt_vld;
    logic [NB_SEL-1:0]  w_gnt;
    logic               w_xfer;

    assign w_load_en = !r_valid || i_ready;
    assign w_xfer    = w_gnt_vld && w_load_en && i_rst_n;

    // Round-robin scans offsets high-to-low so the nearest valid channel from rr_ptr wins last.
    always_comb begin
        int idx;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        idx       = 0;
        if (i_mode) begin
            for (int k = N_INPUTS - 1; k >= 0; k--) begin
                idx = (int'(r_rr_ptr) + k) % N_INPUTS;
                if (i_valid[idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = NB_SEL'(idx);
                end
            end
        end else begin
            for (int k = 0; k < N_INPUTS; k++) begin
                if (int'(i_sel) == k && i_valid[k]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = NB_SEL'(k);
                end
            end
        end
    end

    assign o_ready = w_xfer ? (N_INPUTS'(1) << w_gnt) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_data  <= i_data[int'(w_gnt)*NB_DATA +: NB_DATA];
            r_grant <= w_gnt;
            r_valid <= 1'b1;
            if (i_mode)
                r_rr_ptr <= (int'(w_gnt) == N_INPUTS - 1) ? '0 : w_gnt + NB_SEL'(1);
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_grant = r_grant;
endmodule

// File: tb/tb_mpx_nto1_stream.sv
// tb_mpx_nto1_stream: directed self-checking bench for mpx_nto1_stream (4 channels, 3-bit select to reach out-of-range indices)
module tb_mpx_nto1_stream;
    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [31:0]  d [4];
    logic [127:0] i_data;
    logic [3:0]   i_valid;
    logic [3:0]   o_ready;
    logic         i_mode;
    logic [2:0]   i_sel;
    logic [31:0]  o_data;
    logic         o_valid;
    logic         i_ready;
    logic [2:0]   o_grant;
    int errors = 0;
    int checks = 0;
    logic [1:0] rr_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    assign i_data = {d[3], d[2], d[1], d[0]};

    mpx_nto1_stream #(.NB_DATA(32), .N_INPUTS(4), .NB_SEL(3)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .i_mode(i_mode), .i_sel(i_sel), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_grant(o_grant)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) d[k] = 32'hCAFE0000 | k;
        i_rst_n = 1'b0; i_valid = 4'hF; i_mode = 1'b1; i_sel = 3'd0; i_ready = 1'b1;
        #3;
        chk("rst_valid", o_valid, 0);
        chk("rst_data",  o_data, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_ready", o_ready, 0);
        step(); step();
        i_rst_n = 1'b1; i_mode = 1'b0; i_sel = 3'd2;
        #1;
        chk("fix_ready", o_ready, 4'b0100);
        step();
        chk("fix_valid", o_valid, 1);
        chk("fix_data",  o_data, 32'hCAFE0002);
        chk("fix_grant", o_grant, 2);
        i_sel = 3'd5;
        #1;
        chk("oor_ready", o_ready, 0);
        step();
        chk("oor_valid0", o_valid, 0);
        step();
        chk("oor_valid1", o_valid, 0);
        chk("oor_ready1", o_ready, 0);
        i_mode = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("rr_ready", o_ready, 4'b0001 << rr_exp[c]);
            step();
            chk("rr_grant", o_grant, rr_exp[c]);
            chk("rr_valid", o_valid, 1);
            chk("rr_data",  o_data, 32'hCAFE0000 | rr_exp[c]);
        end
        i_valid = 4'b0010;
        step();
        chk("pre_grant", o_grant, 1);
        i_valid = 4'b1010;
        #1;
        chk("wrap_ready3", o_ready, 4'b1000);
        step();
        chk("wrap_grant3", o_grant, 3);
        #1;
        chk("wrap_ready1", o_ready, 4'b0010);
        step();
        chk("wrap_grant1", o_grant, 1);
        i_mode = 1'b0; i_sel = 3'd0; i_valid = 4'b0001; d[0] = 32'h11;
        step();
        chk("hold_load", o_data, 32'h11);
        i_mode = 1'b1; i_valid = 4'hF; i_ready = 1'b0; d[0] = 32'h22; d[2] = 32'h33;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold_ready", o_ready, 0);
            step();
            chk("hold_data",  o_data, 32'h11);
            chk("hold_valid", o_valid, 1);
            chk("hold_grant", o_grant, 0);
        end
        i_ready = 1'b1;
        #1;
        chk("rel_ready", o_ready, 4'b0100);
        step();
        chk("rel_data",  o_data, 32'h33);
        chk("rel_grant", o_grant, 2);
        i_valid = 4'b0000;
        step();
        chk("drain_valid", o_valid, 0);
        i_valid = 4'b0010; i_ready = 1'b0;
        step();
        chk("mid_grant", o_grant, 1);
        chk("mid_valid", o_valid, 1);
        i_valid = 4'b0000;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_data",  o_data, 0);
        chk("arst_grant", o_grant, 0);
        i_valid = 4'b0110; i_ready = 1'b1;
        #1;
        chk("arst_ready", o_ready, 0);
        step();
        i_rst_n = 1'b1;
        #1;
        chk("post_ready", o_ready, 4'b0010);
        step();
        chk("post_grant", o_grant, 1);
        chk("post_valid", o_valid, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
